// File: rtl/laser_pkg.sv
// Shared types and widths for the multi-requester laser arbiter.
package laser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam int CNT_W  = 32;
  localparam int AMMO_W = 8;

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchroniser for an asynchronous trigger level, followed by a
// rising-edge detector so a held level yields a single one-cycle pulse.
module trigger_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/laser_arbiter.sv
// Round-robin arbiter sharing one active-low laser between N_REQ requesters,
// each shot being a fixed on-window plus cooldown, with per-requester ammo.
module laser_arbiter
  import laser_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ON_CYCLES  = 100000000,
  parameter int OFF_CYCLES = 100000000,
  parameter int AMMO       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           trig,
  input  logic [N_REQ-1:0]           reload,
  output logic                       laser_n,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   active_id,
  output logic                       busy,
  output logic [N_REQ-1:0]           ammo_empty
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [N_REQ-1:0]   rise, pending, has_ammo;
  logic [AMMO_W-1:0]  ammo [N_REQ];
  logic [IDW-1:0]     winner;
  logic               start;

  // First pending requester after 'last', wrapping; lowest distance wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDW-1:0]   last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[IDW'(idx)]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    trigger_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d     (trig[i]),
      .rise  (rise[i])
    );
    assign has_ammo[i] = (ammo[i] != '0);
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    winner   = rr_pick(pending, active_id);
    case (state)
      IDLE: if (|pending) begin
        state_nx = FIRE;
        start    = 1'b1;
      end
      FIRE:    if (cnt == ON_LAST)  state_nx = COOL;
      COOL:    if (cnt == OFF_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  // A new edge in the grant cycle re-arms the bit the grant just cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      active_id <= IDW'(N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) ammo[i] <= AMMO_FULL;
    end else begin
      if (start) active_id <= winner;
      for (int i = 0; i < N_REQ; i++) begin
        if (start && winner == IDW'(i)) pending[i] <= 1'b0;
        if (rise[i] && has_ammo[i])     pending[i] <= 1'b1;
        if (reload[i])
          ammo[i] <= AMMO_FULL;
        else if (start && winner == IDW'(i) && has_ammo[i])
          ammo[i] <= ammo[i] - AMMO_W'(1);
      end
    end
  end

  assign laser_n    = (state != FIRE);
  assign busy       = (state != IDLE);
  assign grant      = (state == FIRE) ? (N_REQ'(1) << active_id) : '0;
  assign ammo_empty = ~has_ammo;

endmodule

// File: tb/tb_laser_arbiter.sv
// Directed and randomized bench for laser_arbiter against a countdown-timer
// reference model of shot sequencing, ammo and round-robin ownership.
module tb_laser_arbiter;

  localparam int N   = 2;
  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int AM  = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] trig = '0;
  logic [N-1:0] reload = '0;
  logic         laser_n;
  logic [N-1:0] grant;
  logic [0:0]   active_id;
  logic         busy;
  logic [N-1:0] ammo_empty;

  laser_arbiter #(.N_REQ(N), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .AMMO(AM)) dut (
    .clock      (clock),
    .reset      (reset),
    .trig       (trig),
    .reload     (reload),
    .laser_n    (laser_n),
    .grant      (grant),
    .active_id  (active_id),
    .busy       (busy),
    .ammo_empty (ammo_empty)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: shot timers count down, history holds past trig samples.
  int       m_on, m_cool, m_owner, m_last;
  int       m_ammo [N];
  bit [N-1:0] m_pend, h1, h2, h3;

  // Observed statistics for directed checks.
  int shots, low_cyc, busy_cyc, ncyc, first_fall, second_fall;
  bit prev_ln;
  int owners [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_on = 0; m_cool = 0; m_owner = 0; m_last = N - 1;
    m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
    for (int i = 0; i < N; i++) m_ammo[i] = AM;
  endfunction

  function automatic void model_edge(input logic [N-1:0] t, input logic [N-1:0] r);
    bit         idle;
    int         win;
    bit [N-1:0] edge_seen;
    bit         has;
    idle = (m_on == 0 && m_cool == 0);
    win = -1;
    edge_seen = h2 & ~h3;
    if (idle)
      for (int k = 1; k <= N; k++)
        if (win < 0 && m_pend[(m_last + k) % N]) win = (m_last + k) % N;
    if (m_on > 0) begin
      m_on--;
      if (m_on == 0) m_cool = OFF;
    end else if (m_cool > 0) begin
      m_cool--;
    end
    if (win >= 0) begin
      m_on = ON; m_owner = win; m_last = win;
    end
    for (int i = 0; i < N; i++) begin
      has = (m_ammo[i] > 0);
      if (win == i) m_pend[i] = 1'b0;
      if (edge_seen[i] && has) m_pend[i] = 1'b1;
      if (r[i]) m_ammo[i] = AM;
      else if (win == i && m_ammo[i] > 0) m_ammo[i]--;
    end
    h3 = h2; h2 = h1; h1 = t;
  endfunction

  task automatic check_model();
    logic [N-1:0] exp_empty;
    for (int i = 0; i < N; i++) exp_empty[i] = (m_ammo[i] == 0);
    chk("laser_n",    laser_n,    32'(m_on == 0));
    chk("grant",      grant,      (m_on > 0) ? (32'd1 << m_owner) : 32'd0);
    chk("busy",       busy,       32'(m_on > 0 || m_cool > 0));
    chk("active_id",  active_id,  32'(m_last));
    chk("ammo_empty", ammo_empty, 32'(exp_empty));
  endtask

  task automatic clear_stats();
    shots = 0; low_cyc = 0; busy_cyc = 0; ncyc = 0;
    first_fall = -1; second_fall = -1;
    owners.delete();
  endtask

  task automatic cyc(input logic [N-1:0] t, input logic [N-1:0] r);
    trig = t;
    reload = r;
    @(posedge clock);
    model_edge(t, r);
    @(negedge clock);
    check_model();
    if (!laser_n) low_cyc++;
    if (busy) busy_cyc++;
    if (prev_ln && !laser_n) begin
      shots++;
      if (first_fall < 0) first_fall = ncyc;
      else if (second_fall < 0) second_fall = ncyc;
      owners.push_back(int'(active_id));
    end
    prev_ln = laser_n;
    ncyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trig = '0;
    reload = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    prev_ln = 1'b1;
    chk("rst_laser_n",    laser_n,    32'd1);
    chk("rst_grant",      grant,      32'd0);
    chk("rst_busy",       busy,       32'd0);
    chk("rst_active_id",  active_id,  32'd1);
    chk("rst_ammo_empty", ammo_empty, 32'd0);
    clear_stats();
  endtask

  initial begin
    logic [N-1:0] rt;

    // Single shot
    do_reset();
    repeat (3) cyc(2'b01, 2'b00);
    repeat (17) cyc(2'b00, 2'b00);
    chk("single_shots", shots, 32'd1);
    chk("single_fall_edge", first_fall, 32'd3);
    chk("single_low_cycles", low_cyc, 32'd4);
    chk("single_busy_cycles", busy_cyc, 32'd7);
    chk("single_owner", owners[0], 32'd0);

    // Simultaneous request
    do_reset();
    repeat (3) cyc(2'b11, 2'b00);
    repeat (25) cyc(2'b00, 2'b00);
    chk("simul_shots", shots, 32'd2);
    chk("simul_first_owner", owners[0], 32'd0);
    chk("simul_second_owner", owners[1], 32'd1);
    chk("simul_fall_gap", second_fall - first_fall, 32'd8);
    chk("simul_active_id", active_id, 32'd1);

    // Ammo exhaustion and reload
    do_reset();
    for (int p = 0; p < 3; p++) begin
      repeat (2) cyc(2'b01, 2'b00);
      repeat (14) cyc(2'b00, 2'b00);
      if (p == 1) chk("ammo0_empty_after_2", ammo_empty[0], 32'd1);
    end
    chk("ammo_shots", shots, 32'd2);
    cyc(2'b00, 2'b01);
    cyc(2'b00, 2'b00);
    chk("ammo0_reloaded", ammo_empty[0], 32'd0);
    repeat (2) cyc(2'b01, 2'b00);
    repeat (14) cyc(2'b00, 2'b00);
    chk("reload_shots", shots, 32'd3);

    // Edge-only triggering
    do_reset();
    repeat (50) cyc(2'b10, 2'b00);
    repeat (10) cyc(2'b00, 2'b00);
    chk("held_shots", shots, 32'd1);
    clear_stats();
    cyc(2'b01, 2'b00);
    repeat (2) cyc(2'b00, 2'b00);
    repeat (3) begin
      cyc(2'b10, 2'b00);
      cyc(2'b00, 2'b00);
    end
    repeat (25) cyc(2'b00, 2'b00);
    chk("busy_press_shots", shots, 32'd2);

    // Async reset mid-shot
    do_reset();
    cyc(2'b01, 2'b00);
    repeat (4) cyc(2'b00, 2'b00);
    chk("pre_reset_laser_on", laser_n, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_laser_n", laser_n, 32'd1);
    chk("async_rst_grant", grant, 32'd0);
    chk("async_rst_busy", busy, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    prev_ln = 1'b1;
    clear_stats();
    repeat (2) begin
      repeat (2) cyc(2'b01, 2'b00);
      repeat (14) cyc(2'b00, 2'b00);
    end
    chk("post_rst_shots", shots, 32'd2);
    chk("post_rst_empty", ammo_empty[0], 32'd1);

    // Round-robin fairness with continuous re-pressing
    do_reset();
    repeat (24) begin
      cyc(2'b11, 2'b11);
      cyc(2'b00, 2'b11);
    end
    chk("rr_enough_shots", 32'(shots >= 4), 32'd1);
    for (int k = 0; k < owners.size(); k++)
      chk("rr_alternate", owners[k], 32'(k % 2));

    // Randomized traffic against the model
    do_reset();
    rt = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) rt[i] = ~rt[i];
      cyc(rt, ($urandom_range(0, 19) == 0) ? N'($urandom_range(1, 3)) : '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
